div_unit: RTL and testbench

Multi-cycle 32-bit integer divider in the EX stage. Executes DIV/DIVU and drives the EX-stage stall request into the pipeline stall controller, so it sits on the requesting side of the stall interface. While a division is in flight it holds stallreq_o high, freezing PC/IF/ID/EX. It then presents a 64-bit {remainder, quotient} result for the HI/LO write path.

---
 rtl/div_unit.sv | 189 ++++++++++++++++++
 tb/tb_div_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit -- multi-cycle 32-bit integer divider for the EX stage (DIV / DIVU).
//
// A restoring divider produces one quotient bit per cycle, MSB first. While a
// division is in flight it raises stallreq_o so the pipeline stall controller
// freezes PC/IF/ID/EX. It then presents {remainder, quotient} for the HI/LO
// write path.
//
// Handshake: EX raises start_i and holds it (operands may change freely after
// the first cycle, they are latched then). ready_o marks result_o as valid and
// stays high, with result_o stable, for as long as start_i stays high. The
// cycle after start_i drops, ready_o and result_o clear. A new start is
// accepted only after start_i has been low for at least one cycle.
//
// Ports:
//   clk          in   1   rising-edge clock
//   rst          in   1   synchronous reset, active low
//   start_i      in   1   division request, held until ready_o is seen
//   annul_i      in   1   abort the in-flight division (pipeline flush)
//   signed_div_i in   1   1 = DIV (signed), 0 = DIVU
//   opdata1_i    in  32   dividend
//   opdata2_i    in  32   divisor
//   result_o     out 64   {remainder[63:32], quotient[31:0]}
//   ready_o      out  1   result_o valid
//   stallreq_o   out  1   stall request (combinational, EX level)
//
// Configuration macro:
//   DIV_ZERO_FAST_EN  when defined, a zero divisor short-cuts through BYZERO
//                     (result 0, ready two cycles after start). When undefined
//                     a zero divisor runs the full sequence.
// -----------------------------------------------------------------------------
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        annul_i,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] dvd_q, dvd_d;     // dividend magnitude, shifted left each step
    logic [31:0] dvs_q, dvs_d;     // divisor magnitude
    logic [31:0] rem_q, rem_d;     // partial remainder
    logic [31:0] quo_q, quo_d;     // quotient bits shifted in from the right
    logic        neg_q_q, neg_q_d; // quotient must be negated at the end
    logic        neg_r_q, neg_r_d; // remainder must be negated at the end
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    // The partial remainder needs 33 bits: with a divisor above 2^31 the
    // remainder can itself have bit 31 set before the next shift.
    logic [32:0] partial;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    always_comb begin
        partial = {rem_q, dvd_q[31]};
        quo_fix = neg_q_q ? (~quo_q + 32'd1) : quo_q;
        rem_fix = neg_r_q ? (~rem_q + 32'd1) : rem_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        result_d = result_q;
        ready_d  = ready_q;

        case (state_q)
            FREE: begin
                ready_d  = 1'b0;
                result_d = 64'd0;
                cnt_d    = 6'd0;
                // A start coinciding with annul is dropped.
                if (start_i && !annul_i) begin
                    dvd_d   = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
                    dvs_d   = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
                    neg_q_d = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                    neg_r_d = signed_div_i && opdata1_i[31];
                    rem_d   = 32'd0;
                    quo_d   = 32'd0;
`ifdef DIV_ZERO_FAST_EN
                    if (opdata2_i == 32'd0) begin
                        state_d = BYZERO;
                    end else begin
                        state_d = ON;
                    end
`else
                    state_d = ON;
`endif
                end
            end

            BYZERO: begin
                if (annul_i) begin
                    state_d = FREE;
                    cnt_d   = 6'd0;
                end else begin
                    state_d  = END;
                    result_d = 64'd0;
                    ready_d  = 1'b1;
                end
            end

            ON: begin
                if (annul_i) begin
                    state_d = FREE;
                    cnt_d   = 6'd0;
                end else if (cnt_q == 6'd32) begin
                    result_d = {rem_fix, quo_fix};
                    ready_d  = 1'b1;
                    state_d  = END;
                end else begin
                    if (partial >= {1'b0, dvs_q}) begin
                        rem_d = partial[31:0] - dvs_q;
                        quo_d = {quo_q[30:0], 1'b1};
                    end else begin
                        rem_d = partial[31:0];
                        quo_d = {quo_q[30:0], 1'b0};
                    end
                    dvd_d = {dvd_q[30:0], 1'b0};
                    cnt_d = cnt_q + 6'd1;
                end
            end

            END: begin
                if (!start_i) begin
                    state_d  = FREE;
                    ready_d  = 1'b0;
                    result_d = 64'd0;
                end
            end

            default: begin
                state_d = FREE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= FREE;
            cnt_q    <= 6'd0;
            dvd_q    <= 32'd0;
            dvs_q    <= 32'd0;
            rem_q    <= 32'd0;
            quo_q    <= 32'd0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            result_q <= 64'd0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    // The pipeline is released in the same cycle the result becomes valid.
    assign stallreq_o = rst & start_i & ~ready_q & ~annul_i;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit -- scoreboard bench for div_unit.
// The driver pushes the expected {remainder, quotient} for every accepted
// division into exp_q; an independent monitor pops and compares on each rising
// ready_o. The driver also checks stallreq_o / ready_o timing cycle by cycle.
// -----------------------------------------------------------------------------
module tb_div_unit;

`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST_ZERO = 1'b1;
`else
    localparam bit FAST_ZERO = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    logic [63:0] exp_q[$];
    int          tests_run    = 0;
    int          tests_failed = 0;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Divide magnitudes with plain arithmetic, then apply the sign rules.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic        na, nb;
        logic [31:0] ma, mb, q, r;
        na = s & a[31];
        nb = s & b[31];
        ma = na ? (32'd0 - a) : a;
        mb = nb ? (32'd0 - b) : b;
        if (mb == 32'd0) begin
            if (FAST_ZERO) return 64'd0;
            q = 32'hFFFF_FFFF;
            r = ma;
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        if (na ^ nb) q = 32'd0 - q;
        if (na) r = 32'd0 - r;
        return {r, q};
    endfunction

    function automatic int ref_lat(input logic [31:0] b);
        return (b == 32'd0 && FAST_ZERO) ? 2 : 34;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic prev_ready = 1'b0;
    always @(negedge clk) begin
        if (ready_o && !prev_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 64'd1, 64'd0);
            end else begin
                check("result", result_o, exp_q.pop_front());
            end
        end
        if (!ready_o) check("result_zero_when_idle", result_o, 64'd0);
        prev_ready = ready_o;
    end

    // ---------------- driver tasks ----------------
    // Enter cycle 0 of a division: start raised just after a rising edge.
    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b, input bit push);
        @(posedge clk); #1;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        if (push) exp_q.push_back(ref_div(s, a, b));
    endtask

    // Called while in cycle 0; waits for ready, checks stall timing, holds
    // start for 'hold' extra cycles, then drops it and checks the clear.
    task automatic wait_done(input int lat, input int hold, input bit change_mid, input logic [63:0] exp);
        int cyc;
        cyc = 0;
        @(negedge clk);
        forever begin
            check("stallreq", {63'd0, stallreq_o}, {63'd0, (cyc < lat)});
            if (ready_o) break;
            if (cyc >= 60) begin
                check("ready_timeout", 64'd0, 64'd1);
                break;
            end
            if (change_mid && cyc == 5) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = ~signed_div_i;
            end
            @(posedge clk); #1;
            cyc++;
            @(negedge clk);
        end
        check("latency", 64'(cyc), 64'(lat));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("hold_ready", {63'd0, ready_o}, 64'd1);
            check("hold_result", result_o, exp);
        end
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        check("drop_cycle_ready", {63'd0, ready_o}, 64'd1);
        check("drop_cycle_stall", {63'd0, stallreq_o}, 64'd0);
        @(negedge clk);
        check("cleared_ready", {63'd0, ready_o}, 64'd0);
        check("cleared_result", result_o, 64'd0);
    endtask

    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input int hold, input bit change_mid);
        issue(s, a, b, 1'b1);
        wait_done(ref_lat(b), hold, change_mid, ref_div(s, a, b));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst          = 1'b0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_stall", {63'd0, stallreq_o}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("reset_ready", {63'd0, ready_o}, 64'd0);
        check("reset_result", result_o, 64'd0);

        // Directed corners.
        run_div(1'b0, 32'd100, 32'd7, 0, 1'b0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_div(1'b0, 32'd5, 32'd0, 0, 1'b0);
        run_div(1'b1, 32'hFFFF_FFFB, 32'd0, 0, 1'b0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 0, 1'b0);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 1'b0);
        // Operands changed mid-divide, start held three extra cycles.
        run_div(1'b0, 32'd123456, 32'd789, 3, 1'b1);

        // Annul in cycle 10, new start in cycle 12.
        issue(1'b0, 32'd1000, 32'd3, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (c == 10) annul_i = 1'b1;
            @(negedge clk);
            if (c == 9) check("pre_annul_stall", {63'd0, stallreq_o}, 64'd1);
        end
        @(posedge clk); #1;
        annul_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        check("annul_ready", {63'd0, ready_o}, 64'd0);
        check("annul_stall", {63'd0, stallreq_o}, 64'd0);
        run_div(1'b1, 32'hFFFF_F000, 32'd9, 0, 1'b0);

        // Reset in cycle 20 of a divide, restart right after release.
        issue(1'b0, 32'd99999, 32'd17, 1'b0);
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 20) rst = 1'b0;
        end
        @(negedge clk);
        check("rst_stall", {63'd0, stallreq_o}, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_ready", {63'd0, ready_o}, 64'd0);
        check("rst_result", result_o, 64'd0);
        check("rst_stall2", {63'd0, stallreq_o}, 64'd0);
        @(posedge clk); #1;
        rst          = 1'b1;
        signed_div_i = 1'b1;
        opdata1_i    = 32'hDEAD_BEEF;
        opdata2_i    = 32'd1234;
        exp_q.push_back(ref_div(1'b1, 32'hDEAD_BEEF, 32'd1234));
        wait_done(ref_lat(32'd1234), 1, 1'b0, ref_div(1'b1, 32'hDEAD_BEEF, 32'd1234));

        // Randomized divides.
        for (int i = 0; i < 16; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(0, 15));
                1:       b = 32'd0 - 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            run_div(1'($urandom_range(0, 1)), a, b, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
